// File: rtl/axi_dram_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_dram_reader : AXI4 read master that fetches word runs from DRAM as
//                   4KB-safe INCR bursts and streams them into a FIFO. Rev 1.0
// ----------------------------------------------------------------------------
module axi_dram_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  kick,
  output logic                  busy,
  input  logic [31:0]           read_addr,
  input  logic [31:0]           read_num,
  output logic [31:0]           buf_dout,
  output logic                  buf_we,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_AR   = 2'd2,
    S_R    = 2'd3
  } state_t;

  localparam logic [31:0] C_MAX_BURST = 32'(MAX_BURST);

  state_t                  state_q;
  logic                    busy_q;
  logic                    buf_we_q;
  logic                    err_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [7:0]              arlen_q;
  logic [31:0]             buf_dout_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             rem_q;
  logic [31:0]             beats_q;
  logic [31:0]             beat_cnt_q;

  logic [12:0]             w_bound_bytes;
  logic [31:0]             w_bound_words;
  logic [31:0]             w_beats;
  logic                    w_last_beat;
  logic [ADDR_WIDTH-1:0]   w_burst_bytes;
  logic                    w_unused;

  // Words left before the next 4KB page; a burst never runs past it.
  assign w_bound_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
  assign w_bound_words = {21'd0, w_bound_bytes[12:2]};

  always_comb begin
    w_beats = rem_q;
    if (w_beats > C_MAX_BURST)   w_beats = C_MAX_BURST;
    if (w_beats > w_bound_words) w_beats = w_bound_words;
  end

  assign w_last_beat   = (beat_cnt_q == beats_q - 32'd1);
  assign w_burst_bytes = ADDR_WIDTH'(beats_q) << 2;
  assign w_unused      = &{1'b0, read_addr[1:0], w_bound_bytes[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      buf_we_q   <= 1'b0;
      err_q      <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      buf_dout_q <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      buf_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (kick && read_num != 32'd0) begin
            addr_q  <= ADDR_WIDTH'({read_addr[31:2], 2'b00});
            rem_q   <= read_num;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          araddr_q  <= addr_q;
          arlen_q   <= 8'(w_beats - 32'd1);
          beats_q   <= w_beats;
          arvalid_q <= 1'b1;
          state_q   <= S_AR;
        end
        S_AR: begin
          if (m_axi_arready) begin
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b1;
            beat_cnt_q <= '0;
            state_q    <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            buf_dout_q <= m_axi_rdata;
            buf_we_q   <= 1'b1;
            beat_cnt_q <= beat_cnt_q + 32'd1;
            // Our own beat count decides the burst end; RLAST is only checked.
            if (m_axi_rresp != 2'b00 || m_axi_rlast != w_last_beat) err_q <= 1'b1;
            if (w_last_beat) begin
              addr_q   <= addr_q + w_burst_bytes;
              rem_q    <= rem_q - beats_q;
              rready_q <= 1'b0;
              if (rem_q == beats_q) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_CALC;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign buf_we        = buf_we_q;
  assign buf_dout      = buf_dout_q;
  assign err           = err_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_dram_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axi_dram_reader : randomized AXI slave plus word/burst reference model.
// ----------------------------------------------------------------------------
module tb_axi_dram_reader;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kick = 1'b0;
  logic [31:0] read_addr = '0;
  logic [31:0] read_num = '0;
  logic        busy, buf_we, err;
  logic [31:0] buf_dout;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_rready;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;

  always #5 clk = ~clk;

  axi_dram_reader #(.ADDR_WIDTH(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .kick(kick), .busy(busy),
    .read_addr(read_addr), .read_num(read_num),
    .buf_dout(buf_dout), .buf_we(buf_we), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int errors = 0;
  int checks = 0;

  // Slave memory contents: a fixed hash of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // idx-th burst of a request as {found, addr, len}; zero when there is none.
  function automatic logic [40:0] nth_burst(input logic [31:0] a0, input logic [31:0] n, input int idx);
    logic [31:0] a;
    longint      rem, b, room;
    a   = {a0[31:2], 2'b00};
    rem = longint'(n);
    for (int i = 0; i < 100000 && rem != 0; i++) begin
      b    = (rem < MAXB) ? rem : MAXB;
      room = (4096 - longint'(a[11:0])) / 4;
      if (b > room) b = room;
      if (i == idx) return {1'b1, a, 8'(b - 1)};
      a   = a + 32'(4 * b);
      rem = rem - b;
    end
    return '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave and model state
  logic [31:0] sq_addr[$];
  logic [7:0]  sq_len[$];
  logic [31:0] eq_addr[$];
  logic [7:0]  eq_len[$];
  logic [31:0] ew[$];
  int  bi = 0, gk = 0, wk = 0, stall_cnt = 0;
  bit  rv = 0, m_active = 0, m_err = 0, prev_stall = 0;
  int  bad_resp = -1, bad_last = -1;
  int  cfg_stall = 0, cfg_rv_pct = 100, cfg_ar_pct = 100, cfg_bad_resp = -1, cfg_bad_last = -1;

  initial begin : env
    logic [40:0] nb;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sq_addr.delete(); sq_len.delete(); eq_addr.delete(); eq_len.delete(); ew.delete();
        m_active = 0; m_err = 0; rv = 0; bi = 0; gk = 0; wk = 0; stall_cnt = 0; prev_stall = 0;
      end else begin
        if (kick && !m_active && read_num != 32'd0) begin
          for (int i = 0; i < 100000; i++) begin
            nb = nth_burst(read_addr, read_num, i);
            if (!nb[40]) break;
            eq_addr.push_back(nb[39:8]);
            eq_len.push_back(nb[7:0]);
          end
          for (longint k = 0; k < longint'(read_num); k++)
            ew.push_back(mem_word({read_addr[31:2], 2'b00} + 32'(4 * k)));
          m_active = 1; m_err = 0; wk = 0; gk = 0;
          bad_resp = cfg_bad_resp; bad_last = cfg_bad_last;
        end
        if (m_axi_arvalid && m_axi_arready) begin
          sq_addr.push_back(m_axi_araddr);
          sq_len.push_back(m_axi_arlen);
          stall_cnt = 0;
        end
        if (m_axi_rvalid && m_axi_rready && sq_addr.size() > 0) begin
          rv = 0;
          gk++;
          if (bi == int'(sq_len[0])) begin
            void'(sq_addr.pop_front()); void'(sq_len.pop_front()); bi = 0;
          end else bi++;
        end
      end
      #1;
      if (!rst_n) begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      end else begin
        if (m_axi_arvalid && stall_cnt < cfg_stall) begin
          m_axi_arready = 1'b0; stall_cnt++;
        end else m_axi_arready = (int'($urandom_range(0, 99)) < cfg_ar_pct);
        if (!rv && sq_addr.size() > 0 && int'($urandom_range(0, 99)) < cfg_rv_pct) rv = 1;
        m_axi_rvalid = rv;
        if (rv) begin
          m_axi_rdata = mem_word(sq_addr[0] + 32'(4 * bi));
          m_axi_rresp = (gk == bad_resp) ? 2'b10 : 2'b00;
          m_axi_rlast = (bi == int'(sq_len[0])) ^ (gk == bad_last);
        end else begin
          m_axi_rdata = $urandom; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        end
      end
      @(negedge clk);
      if (buf_we) begin
        if (ew.size() == 0) begin
          checks++; errors++;
          $display("FAIL buf_we: unexpected write of %0h, none required", buf_dout);
        end else begin
          chk("buf_dout", buf_dout, ew.pop_front());
          if (wk == bad_resp || wk == bad_last) m_err = 1;
          wk++;
          if (ew.size() == 0) m_active = 0;
        end
      end
      chk("busy", busy, m_active);
      chk("err", err, m_err);
      if (!m_active) chk("rready_idle", m_axi_rready, 0);
      if (prev_stall) chk("arvalid_hold", m_axi_arvalid, 1);
      if (m_axi_arvalid) begin
        chk("arsize", m_axi_arsize, 3'b010);
        chk("arburst", m_axi_arburst, 2'b01);
        if (eq_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar: unexpected AR addr %0h len %0d, none required", m_axi_araddr, m_axi_arlen);
        end else begin
          chk("araddr", m_axi_araddr, eq_addr[0]);
          chk("arlen", m_axi_arlen, eq_len[0]);
          if (m_axi_arready) begin void'(eq_addr.pop_front()); void'(eq_len.pop_front()); end
        end
      end
      prev_stall = m_axi_arvalid && !m_axi_arready;
    end
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #2;
      if (!m_active && eq_addr.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL timeout: busy model still %0d after 3000 cycles, required 0", m_active);
    do_reset();
  endtask

  task automatic pulse_kick(input logic [31:0] a, input logic [31:0] n);
    @(negedge clk); read_addr = a; read_num = n; kick = 1'b1;
    @(negedge clk); kick = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] n);
    pulse_kick(a, n);
    wait_idle();
  endtask

  initial begin : main
    logic [31:0] a;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_buf_dout", buf_dout, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    rst_n = 1'b1;

    chk("pin_t1_b0", nth_burst(32'h100, 4, 0), {1'b1, 32'h100, 8'd3});
    chk("pin_t1_b1", nth_burst(32'h100, 4, 1), 41'd0);
    chk("pin_t2_b0", nth_burst(32'h0, 40, 0), {1'b1, 32'h000, 8'd15});
    chk("pin_t2_b1", nth_burst(32'h0, 40, 1), {1'b1, 32'h040, 8'd15});
    chk("pin_t2_b2", nth_burst(32'h0, 40, 2), {1'b1, 32'h080, 8'd7});
    chk("pin_t2_b3", nth_burst(32'h0, 40, 3), 41'd0);
    chk("pin_t3_b0", nth_burst(32'hFF8, 6, 0), {1'b1, 32'hFF8, 8'd1});
    chk("pin_t3_b1", nth_burst(32'hFF8, 6, 1), {1'b1, 32'h1000, 8'd3});
    chk("pin_wrap_b1", nth_burst(32'hFFFF_FFF8, 4, 1), {1'b1, 32'h0, 8'd1});

    do_req(32'h100, 4);
    do_req(32'h0, 40);
    do_req(32'hFFB, 6);
    cfg_stall = 10; cfg_rv_pct = 50; cfg_ar_pct = 70;
    do_req(32'h2000, 20);
    cfg_stall = 0; cfg_rv_pct = 100; cfg_ar_pct = 100;

    cfg_bad_resp = 1;
    do_req(32'h300, 4);
    chk("err_sticky", err, 1);
    cfg_bad_resp = -1;
    pulse_kick(32'h400, 8);
    repeat (3) @(negedge clk);
    pulse_kick(32'h800, 8);
    wait_idle();
    chk("err_cleared", err, 0);
    pulse_kick(32'h900, 0);
    repeat (10) @(negedge clk);
    cfg_bad_last = 3; do_req(32'h500, 4);
    cfg_bad_last = 0; do_req(32'h600, 4);
    cfg_bad_last = -1;

    cfg_bad_resp = 2;
    pulse_kick(32'h0, 40);
    for (int c = 0; c < 200 && wk < 5; c++) begin @(negedge clk); #2; end
    cfg_bad_resp = -1;
    do_reset();
    #2;
    chk("rst6_busy", busy, 0);
    chk("rst6_arvalid", m_axi_arvalid, 0);
    chk("rst6_rready", m_axi_rready, 0);
    chk("rst6_buf_we", buf_we, 0);
    chk("rst6_err", err, 0);
    do_req(32'h1234, 10);

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom;
        1:       a = 32'(($urandom_range(1, 15)) * 4096) - 32'(4 * $urandom_range(0, 20));
        default: a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      endcase
      cfg_stall    = int'($urandom_range(0, 3));
      cfg_rv_pct   = int'($urandom_range(30, 100));
      cfg_ar_pct   = int'($urandom_range(30, 100));
      cfg_bad_resp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
      cfg_bad_last = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
      do_req(a, 32'($urandom_range(1, 70)));
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
